approx_err_sweeper: RTL and testbench

Self-checking characterisation engine for approximate multipliers. It runs an exhaustive operand sweep over a W×W-bit exact multiplier and an approximate multiplier in lockstep, and accumulates error statistics in hardware. It returns the sum of absolute error, the maximum error and its operands, and the count of erroneous products. It sits beside the exact/approximate Vedic multiplier pair in the DCT datapath, so characterisation runs on silicon or FPGA instead of in a file-dumping bench.

---
 rtl/approx_err_sweeper.sv | 192 +++++++++++++++++++
 tb/tb_approx_err_sweeper.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/approx_err_sweeper.sv
// rtl/approx_err_sweeper.sv - exhaustive exact-vs-approximate multiplier error characterisation engine
// Optional ERR_SQ_EN adds err_sq_sum (sum of squared error) through a registered squarer stage.
module approx_err_sweeper #(
  parameter int W   = 8,
  parameter int LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [W-1:0]     op_a,
  output logic [W-1:0]     op_b,
  output logic             op_valid,
  input  logic [2*W-1:0]   p_exact,
  input  logic [2*W-1:0]   p_approx,
  output logic             busy,
  output logic             done,
  output logic [4*W-1:0]   err_sum,
  output logic [2*W-1:0]   err_max,
  output logic [W-1:0]     max_a,
  output logic [W-1:0]     max_b,
  output logic [2*W:0]     err_cnt
`ifdef ERR_SQ_EN
  ,
  output logic [6*W-1:0]   err_sq_sum
`endif
);

`ifdef ERR_SQ_EN
  localparam int SQ_LAT = 1;
`else
  localparam int SQ_LAT = 0;
`endif
  localparam int DRAIN_LEN = LAT + SQ_LAT;
  localparam int CW = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'((DRAIN_LEN > 0) ? DRAIN_LEN - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_clear;
  logic [2*W-1:0]      r_cnt;
  logic [CW-1:0]       r_drain;
  logic                w_op_valid;
  logic                w_tap_vld;
  logic [2*W-1:0]      w_tap_tag;
  logic [2*W:0]        w_d;
  logic [2*W-1:0]      w_abs;
  logic [4*W-1:0]      r_err_sum;
  logic [2*W-1:0]      r_err_max;
  logic [W-1:0]        r_max_a;
  logic [W-1:0]        r_max_b;
  logic [2*W:0]        r_err_cnt;

  assign w_op_valid = (r_state == S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // abort overrides everything, including a coincident start
  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next  = S_RUN;
          w_clear = 1'b1;
        end
      end
      S_RUN: begin
        if (&r_cnt) w_next = (DRAIN_LEN > 0) ? S_DRAIN : S_DONE;
      end
      S_DRAIN: begin
        if (r_drain == DRAIN_LAST) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
    if (abort) begin
      w_next  = S_IDLE;
      w_clear = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_drain <= '0;
    end else begin
      if (abort || w_clear)    r_cnt <= '0;
      else if (w_op_valid)     r_cnt <= r_cnt + {{(2*W-1){1'b0}}, 1'b1};
      if (r_state == S_RUN)    r_drain <= '0;
      else if (r_state == S_DRAIN) r_drain <= r_drain + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // operand tag travels with the multipliers so the tap lines up with the products
  generate
    if (LAT == 0) begin : g_tap_direct
      assign w_tap_vld = w_op_valid;
      assign w_tap_tag = r_cnt;
    end else begin : g_tap_pipe
      logic           r_pv [LAT];
      logic [2*W-1:0] r_pt [LAT];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LAT; i++) begin
            r_pv[i] <= 1'b0;
            r_pt[i] <= '0;
          end
        end else begin
          r_pv[0] <= w_op_valid && !abort;
          r_pt[0] <= r_cnt;
          for (int i = 1; i < LAT; i++) begin
            r_pv[i] <= r_pv[i-1] && !abort;
            r_pt[i] <= r_pt[i-1];
          end
        end
      end
      assign w_tap_vld = r_pv[LAT-1];
      assign w_tap_tag = r_pt[LAT-1];
    end
  endgenerate

  assign w_d   = {1'b0, p_exact} - {1'b0, p_approx};
  assign w_abs = w_d[2*W] ? (~w_d[2*W-1:0] + {{(2*W-1){1'b0}}, 1'b1}) : w_d[2*W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_sum <= '0;
      r_err_max <= '0;
      r_max_a   <= '0;
      r_max_b   <= '0;
      r_err_cnt <= '0;
    end else if (abort || w_clear) begin
      r_err_sum <= '0;
      r_err_max <= '0;
      r_max_a   <= '0;
      r_max_b   <= '0;
      r_err_cnt <= '0;
    end else if (w_tap_vld) begin
      r_err_sum <= r_err_sum + {{(2*W){1'b0}}, w_abs};
      if (w_abs != '0) r_err_cnt <= r_err_cnt + {{(2*W){1'b0}}, 1'b1};
      if (w_abs > r_err_max) begin
        r_err_max <= w_abs;
        r_max_a   <= w_tap_tag[2*W-1:W];
        r_max_b   <= w_tap_tag[W-1:0];
      end
    end
  end

`ifdef ERR_SQ_EN
  logic [4*W-1:0] w_abs_x;
  logic [4*W-1:0] r_sq;
  logic           r_sq_vld;
  logic [6*W-1:0] r_err_sq_sum;

  assign w_abs_x = {{(2*W){1'b0}}, w_abs};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sq         <= '0;
      r_sq_vld     <= 1'b0;
      r_err_sq_sum <= '0;
    end else if (abort || w_clear) begin
      r_sq_vld     <= 1'b0;
      r_err_sq_sum <= '0;
    end else begin
      r_sq     <= w_abs_x * w_abs_x;
      r_sq_vld <= w_tap_vld;
      if (r_sq_vld) r_err_sq_sum <= r_err_sq_sum + {{(2*W){1'b0}}, r_sq};
    end
  end

  assign err_sq_sum = r_err_sq_sum;
`endif

  assign op_a     = r_cnt[2*W-1:W];
  assign op_b     = r_cnt[W-1:0];
  assign op_valid = w_op_valid;
  assign busy     = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done     = (r_state == S_DONE);
  assign err_sum  = r_err_sum;
  assign err_max  = r_err_max;
  assign max_a    = r_max_a;
  assign max_b    = r_max_b;
  assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_approx_err_sweeper.sv
// tb/tb_approx_err_sweeper.sv - six parallel sweepers against behavioural exact/approximate multipliers
// Optional ERR_SQ_EN checks err_sq_sum and the extra cycle of latency.
module tb_approx_err_sweeper;

  localparam int NI = 6;
`ifdef ERR_SQ_EN
  localparam int SQ = 1;
`else
  localparam int SQ = 0;
`endif

  logic            clk;
  logic [NI-1:0]   rst_n;
  logic [NI-1:0]   start;
  logic [NI-1:0]   abort;
  logic [7:0]      op_a     [NI];
  logic [7:0]      op_b     [NI];
  logic            op_valid [NI];
  logic [15:0]     p_exact  [NI];
  logic [15:0]     p_approx [NI];
  logic            busy     [NI];
  logic            done     [NI];
  logic [31:0]     err_sum  [NI];
  logic [15:0]     err_max  [NI];
  logic [7:0]      max_a    [NI];
  logic [7:0]      max_b    [NI];
  logic [16:0]     err_cnt  [NI];
`ifdef ERR_SQ_EN
  logic [47:0]     err_sq_sum [NI];
`endif

  int n_chk  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 0 exact, 1 bit0 cleared, 2 +3 wrapping, 3 bit15 cleared
  function automatic logic [15:0] approx_of(int m, logic [15:0] e);
    case (m)
      1:       return e & 16'hFFFE;
      2:       return e + 16'd3;
      3:       return e & 16'h7FFF;
      default: return e;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_u
    localparam int L = (g == 4) ? 3 : 1;
    localparam int M = (g < 4) ? g : 1;
    logic [15:0] pipe [L];
    always @(posedge clk) begin
      pipe[0] <= {8'h00, op_a[g]} * {8'h00, op_b[g]};
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
    assign p_exact[g]  = pipe[L-1];
    assign p_approx[g] = approx_of(M, pipe[L-1]);

    approx_err_sweeper #(.W(8), .LAT(L)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n[g]),
      .start    (start[g]),
      .abort    (abort[g]),
      .op_a     (op_a[g]),
      .op_b     (op_b[g]),
      .op_valid (op_valid[g]),
      .p_exact  (p_exact[g]),
      .p_approx (p_approx[g]),
      .busy     (busy[g]),
      .done     (done[g]),
      .err_sum  (err_sum[g]),
      .err_max  (err_max[g]),
      .max_a    (max_a[g]),
      .max_b    (max_b[g]),
`ifdef ERR_SQ_EN
      .err_sq_sum (err_sq_sum[g]),
`endif
      .err_cnt  (err_cnt[g])
    );
  end

  typedef struct {
    longint sum;
    longint emax;
    longint ma;
    longint mb;
    longint cnt;
    longint done_k;
    longint sq;
  } exp_t;

  exp_t   tbl [NI];
  longint first_done [NI];

  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_zero(int g, string tag);
    chk($sformatf("%s u%0d op_valid", tag, g), longint'(op_valid[g]), 0);
    chk($sformatf("%s u%0d busy", tag, g), longint'(busy[g]), 0);
    chk($sformatf("%s u%0d done", tag, g), longint'(done[g]), 0);
    chk($sformatf("%s u%0d op_a/op_b", tag, g), longint'({op_a[g], op_b[g]}), 0);
    chk($sformatf("%s u%0d err_sum", tag, g), longint'(err_sum[g]), 0);
    chk($sformatf("%s u%0d err_max", tag, g), longint'(err_max[g]), 0);
    chk($sformatf("%s u%0d max_a/max_b", tag, g), longint'({max_a[g], max_b[g]}), 0);
    chk($sformatf("%s u%0d err_cnt", tag, g), longint'(err_cnt[g]), 0);
  endtask

  initial begin
    longint cnt15;
    int     k;
    bit     all_done;

    cnt15 = 0;
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 256; b++)
        if (a * b >= 32768) cnt15++;

    //           sum          emax   ma   mb   cnt    done_k           sq
    tbl[0] = '{0,           0,     0,   0,   0,     65537 + SQ, 0};
    tbl[1] = '{16384,       1,     1,   1,   16384, 65537 + SQ, 16384};
    tbl[2] = '{196608,      3,     0,   0,   65536, 65537 + SQ, 9 * 65536};
    tbl[3] = '{32768*cnt15, 32768, 129, 255, cnt15, 65537 + SQ, (longint'(1) << 30) * cnt15};
    tbl[4] = '{16384,       1,     1,   1,   16384, 65539 + SQ, 16384};
    tbl[5] = '{16384,       1,     1,   1,   16384, 65537 + SQ, 16384};

    rst_n = '0;
    start = '0;
    abort = '0;
    repeat (3) step();
    for (int g = 0; g < NI; g++) check_zero(g, "reset");
    rst_n = '1;
    step();

    // phase A: u4 aborted mid-run, u5 reset mid-run
    start[4] = 1'b1;
    start[5] = 1'b1;
    step();
    start = '0;
    chk("u4 busy after start", longint'(busy[4]), 1);
    chk("u4 op_valid after start", longint'(op_valid[4]), 1);
    for (k = 1; k <= 1003; k++) begin
      step();
      if (k == 500) begin
        chk("u5 err_cnt before reset", longint'(err_cnt[5] != 0), 1);
        rst_n[5] = 1'b0;
        #1;
        check_zero(5, "midreset");
      end
      if (k == 501) rst_n[5] = 1'b1;
      if (k == 999) abort[4] = 1'b1;
      if (k == 1000) begin
        abort[4] = 1'b0;
        chk("u4 busy after abort", longint'(busy[4]), 0);
        chk("u4 err_cnt after abort", longint'(err_cnt[4]), 0);
        chk("u4 err_sum after abort", longint'(err_sum[4]), 0);
        chk("u4 op_valid after abort", longint'(op_valid[4]), 0);
        chk("u5 no resume after reset", longint'(busy[5]), 0);
      end
    end
    chk("u4 in-flight dropped", longint'(err_cnt[4]), 0);
    chk("u4 done after abort", longint'(done[4]), 0);

    // phase B: all six sweep together; u5 sees a start pulse while busy
    start = '1;
    step();
    start = '0;
    for (int g = 0; g < NI; g++) first_done[g] = -1;
    chk("u0 op_valid at E0", longint'(op_valid[0]), 1);
    chk("u0 busy at E0", longint'(busy[0]), 1);
    k = 0;
    all_done = 1'b0;
    while (!all_done && k < 66000) begin
      step();
      k++;
      if (k == 100) start[5] = 1'b1;
      if (k == 101) start[5] = 1'b0;
      if (k == 65535) chk("u0 op_valid last pair", longint'(op_valid[0]), 1);
      if (k == 65536) chk("u0 op_valid after sweep", longint'(op_valid[0]), 0);
      all_done = 1'b1;
      for (int g = 0; g < NI; g++) begin
        if (done[g] && first_done[g] < 0) first_done[g] = k;
        if (first_done[g] < 0) all_done = 1'b0;
      end
    end

    for (int g = 0; g < NI; g++) begin
      chk($sformatf("u%0d done edge", g), first_done[g], tbl[g].done_k);
      chk($sformatf("u%0d err_sum", g), longint'(err_sum[g]), tbl[g].sum);
      chk($sformatf("u%0d err_max", g), longint'(err_max[g]), tbl[g].emax);
      chk($sformatf("u%0d max_a", g), longint'(max_a[g]), tbl[g].ma);
      chk($sformatf("u%0d max_b", g), longint'(max_b[g]), tbl[g].mb);
      chk($sformatf("u%0d err_cnt", g), longint'(err_cnt[g]), tbl[g].cnt);
`ifdef ERR_SQ_EN
      chk($sformatf("u%0d err_sq_sum", g), longint'(err_sq_sum[g]), tbl[g].sq);
`endif
    end

    repeat (5) step();
    chk("u1 done held", longint'(done[1]), 1);
    chk("u1 busy low in DONE", longint'(busy[1]), 0);
    chk("u1 err_cnt held", longint'(err_cnt[1]), tbl[1].cnt);
    chk("u3 max_a held", longint'(max_a[3]), tbl[3].ma);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
